// File: rtl/hs_arb_pkg.sv
// Shared types and defaults for the valid/ready round-robin arbiter.
// Optional beat-limit release is enabled with ARB_BEAT_LIMIT_EN.
package hs_arb_pkg;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

   localparam int DEF_N         = 3;
   localparam int DEF_W         = 3;
   localparam int DEF_MAX_BEATS = 8;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hs_rr_arbiter_pick.sv
// Combinational round-robin pick: first requester at or after ptr.
// Part of hs_rr_arbiter (optional macro ARB_BEAT_LIMIT_EN lives in the top).
module rr_pick
   import hs_arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int PW = ptr_w(DEF_N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          any,
   output logic [PW-1:0] idx
);

   // Scan from the far end so the nearest hit to ptr is written last.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            any = 1'b1;
            idx = PW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin valid/ready burst arbiter, N masters onto one slave.
// Define ARB_BEAT_LIMIT_EN to force a release after MAX_BEATS beats.
module hs_rr_arbiter
   import hs_arb_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int W         = DEF_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic [N-1:0]   m_valid,
   input  logic [N*W-1:0] m_data,
   input  logic [N-1:0]   m_last,
   output logic [N-1:0]   m_ready,
   output logic           s_valid,
   output logic [W-1:0]   s_data,
   output logic           s_last,
   input  logic           s_ready,
   output logic [N-1:0]   grant,
   output logic           busy
);

   localparam int PW = ptr_w(N);
   localparam int BW = $clog2(MAX_BEATS + 1);

   arb_state_t    state, state_n;
   logic [N-1:0]  grant_n;
   logic [PW-1:0] rr_ptr, rr_ptr_n;
   logic [BW-1:0] beat_cnt, beat_cnt_n;

   logic          win_any;
   logic [PW-1:0] win_idx;
   logic          hs, release_pt, arb_pt;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req (m_valid),
      .ptr (rr_ptr),
      .any (win_any),
      .idx (win_idx)
   );

   // grant is zero whenever IDLE, so masking by it covers both states.
   assign s_valid = |(m_valid & grant);
   assign s_last  = |(m_last & grant);
   assign m_ready = grant & {N{s_ready}};
   assign busy    = (state == LOCKED);

   always_comb begin
      s_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) s_data = s_data | m_data[i*W +: W];
      end
   end

   assign hs = s_valid & s_ready;

`ifdef ARB_BEAT_LIMIT_EN
   assign release_pt = hs & (s_last | (beat_cnt == BW'(MAX_BEATS - 1)));
`else
   assign release_pt = hs & s_last;
`endif

   assign arb_pt = (state == IDLE) | release_pt;

   always_comb begin
      state_n    = state;
      grant_n    = grant;
      rr_ptr_n   = rr_ptr;
      beat_cnt_n = beat_cnt;
      if (arb_pt) begin
         if (win_any) begin
            state_n          = LOCKED;
            grant_n          = '0;
            grant_n[win_idx] = 1'b1;
            rr_ptr_n         = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
            beat_cnt_n       = '0;
         end else begin
            state_n = IDLE;
            grant_n = '0;
         end
      end else if (hs && beat_cnt != BW'(MAX_BEATS)) begin
         beat_cnt_n = beat_cnt + BW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         rr_ptr   <= rr_ptr_n;
         beat_cnt <= beat_cnt_n;
      end
   end

endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready slave channel among N valid/ready masters.
- Each master's transfer is a burst of 3-bit beats terminated by a `last` flag.
- Once granted, a master holds the channel until its last beat is accepted.
- Sits between the test-data masters and the single downstream consumer.

Parameters:
- N, 3, number of requesting masters (2..8).
- W, 3, data width per beat.
- MAX_BEATS, 8, beat limit per grant; used only when ARB_BEAT_LIMIT_EN is defined.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- m_valid  in  N  per-master valid.
- m_data  in  N*W  per-master data; master i occupies bits [i*W +: W].
- m_last  in  N  per-master last-beat flag.
- m_ready  out  N  per-master ready.
- s_valid  out  1  valid toward slave.
- s_data  out  W  data toward slave.
- s_last  out  1  last toward slave.
- s_ready  in  1  slave ready.
- grant  out  N  one-hot current owner; 0 when idle.
- busy  out  1  high while state is LOCKED.

Behaviour:
- States: IDLE, LOCKED. Registers: state, grant, rr_ptr (clog2(N) bits), beat_cnt.
- Reset (sys_rst=1 at an edge):
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - An in-flight burst is abandoned. Masters see m_ready=0 from the next cycle.
- Outputs while IDLE: s_valid=0, s_data=0, s_last=0, m_ready=0, busy=0.
- Outputs while LOCKED (owner g), combinational pass-through, zero added latency:
  - s_valid=m_valid[g], s_data=m_data[g], s_last=m_last[g].
  - m_ready[g]=s_ready; all other m_ready=0.
- Handshake: a beat transfers when s_valid and s_ready are both high at an edge.
- Arbitration point: any cycle where state=IDLE, or where a last-beat handshake (s_valid & s_ready & s_last) occurs.
- Pick rule:
  - The winner is the first i with m_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, wrapping mod N.
  - On a win: grant<=onehot(winner), state<=LOCKED, rr_ptr<=(winner+1) mod N, beat_cnt<=0.
  - With no request at the arbitration point: state<=IDLE, grant<=0; rr_ptr is unchanged.
- Latency:
  - 1 cycle from m_valid rising in IDLE to grant and m_ready being visible.
  - Back-to-back bursts: the next owner is granted in the cycle after the last beat, with no idle bubble.
- If the finishing owner still has m_valid high, it competes normally. rr_ptr has already advanced past it, so other requesters win first.
- Non-last handshake: beat_cnt<=beat_cnt+1 and the grant holds.
- Backpressure (s_ready=0): all state holds and outputs are stable.
- A master must hold m_valid, m_data and m_last stable until its handshake. The arbiter does not check this rule.
- A single-beat burst (m_last=1 on the first beat) releases the grant after 1 handshake.
- Width: beat_cnt is clog2(MAX_BEATS+1) bits and saturates at MAX_BEATS.

Optional Feature:
- Macro: ARB_BEAT_LIMIT_EN.
- Defined:
  - A handshake where beat_cnt==MAX_BEATS-1 is treated as an arbitration point even if s_last=0. This is a forced release.
  - The preempted master loses its grant and must re-arbitrate for its remaining beats.
  - s_last is not altered.
- Undefined: the grant is released only on s_last. beat_cnt is still maintained for debug.

Decomposition:
- Package hs_arb_pkg holds:
  - state enum {IDLE, LOCKED};
  - localparams DEF_N=3, DEF_W=3, DEF_MAX_BEATS=8;
  - a clog2-based pointer-width function.
- Sub-module rr_pick (combinational): inputs req[N] and ptr; outputs any and idx.
- Top level holds the FSM, registers and the output muxing.

Test Plan:
- Single burst: master0 sends beats 3'b111, 3'b101, 3'b110 (last on the 3rd), s_ready=1.
  - grant=001 one cycle after valid.
  - s_data shows the 3 values on consecutive cycles.
  - Return to IDLE; rr_ptr=1.
- Contention: all 3 masters raise 2-beat bursts in the same cycle.
  - Grants in order 001, 010, 100, with no bubble between bursts.
  - Exactly 6 handshakes total.
- Backpressure: s_ready=0 for 4 cycles mid-burst.
  - s_data, grant and beat_cnt are stable throughout.
  - m_ready for the owner is 0 throughout.
  - Resumes with the correct next beat.
- Fairness: master0 requests continuously; master2 raises a request during master0's burst.
  - master2 is granted next, before master0's second burst.
- Reset mid-burst: assert sys_rst on beat 2.
  - Next cycle: grant=0, s_valid=0, busy=0, rr_ptr=0.
  - A re-request is granted to the lowest index.
- With ARB_BEAT_LIMIT_EN and MAX_BEATS=4: master0 sends a 6-beat burst while master1 is waiting.
  - Grant switches to master1 after beat 4.
  - master0 resumes after master1's burst.
